calu_seq: RTL and testbench

- Parametrised next-generation complex ALU for the project datapath.
- Operands are packed complex numbers {Re, Im}, each component a W-bit signed two's-complement value, fixed-point with FRAC fraction bits.
- Uses a start/busy/done handshake with operand capture at start.
- Multiplies run on one shared W×W multiplier sequenced by an FSM.
- Adds overflow reporting and conjugate operations.

---
 rtl/calu_seq.sv | 185 ++++++++++++++++++
 tb/tb_calu_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calu_seq.sv
`default_nettype none
// ============================================================================
// calu_seq : sequential complex ALU, one shared WxW multiplier, start/busy/done
// Optional build macro: CALU_SAT_EN (saturate instead of wrap on overflow)
// Revision: 1.0
// ============================================================================
module calu_seq #(
  parameter int W    = 32,
  parameter int FRAC = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [2*W-1:0] inA,
  input  logic [2*W-1:0] inB,
  input  logic [3:0]     opr,
  input  logic           start,
  output logic [2*W-1:0] outAB,
  output logic           done,
  output logic           busy,
  output logic           ovf
);
  localparam int AW = 2*W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_NORM = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2*W-1:0]        r_a, r_b, r_out;
  logic [3:0]            r_opr;
  logic [1:0]            r_cnt;
  logic signed [AW-1:0]  r_acc_re, r_acc_im;
  logic                  r_done, r_ovf;

  logic                  w_accept, w_is_mul, w_last, w_to_re, w_neg;
  logic [W-1:0]          w_ra, w_ia, w_rb, w_ib;
  logic signed [W-1:0]   w_mx, w_my;
  logic signed [2*W-1:0] w_prod;
  logic signed [AW-1:0]  w_ext, w_term, w_sh_re, w_sh_im;
  logic [W:0]            w_e_re, w_e_im, w_n_re, w_n_im, w_m_re, w_m_im;
  logic                  w_e_raw;
  logic [2*W-1:0]        w_e_word;

  // {overflow, narrowed value}; overflow when the bits above W-1 are not a pure sign extension
  function automatic logic [W:0] narrow(input logic signed [AW-1:0] v);
    logic         o;
    logic [W-1:0] r;
    o = !((&v[AW-1:W-1]) || !(|v[AW-1:W-1]));
    r = v[W-1:0];
`ifdef CALU_SAT_EN
    if (o) r = v[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {o, r};
  endfunction

  function automatic logic signed [AW-1:0] sx1(input logic [W:0] v);
    return {{(AW-W-1){v[W]}}, v};
  endfunction

  assign w_ra  = r_a[2*W-1:W];
  assign w_ia  = r_a[W-1:0];
  assign w_rb  = r_b[2*W-1:W];
  assign w_ib  = r_b[W-1:0];
  assign busy  = (r_state != S_IDLE);
  assign outAB = r_out;
  assign done  = r_done;
  assign ovf   = r_ovf;

  assign w_is_mul = (opr == 4'b0100) || (opr == 4'b0110) || (opr == 4'b0111);
  assign w_last   = (r_opr == 4'b0110) ? (r_cnt == 2'd1) : (r_cnt == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = w_is_mul ? S_MUL : S_EXEC;
      end
      S_EXEC:  w_state_nxt = S_IDLE;
      S_MUL:   if (w_last) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Product order per step: ac, bd, ad, bc
  always_comb begin
    case (r_cnt)
      2'd0:    begin w_mx = w_ra; w_my = w_rb; end
      2'd1:    begin w_mx = w_ia; w_my = w_ib; end
      2'd2:    begin w_mx = w_ra; w_my = w_ib; end
      default: begin w_mx = w_ia; w_my = w_rb; end
    endcase
  end

  assign w_prod  = $signed({{W{w_mx[W-1]}}, w_mx}) * $signed({{W{w_my[W-1]}}, w_my});
  assign w_ext   = {{2{w_prod[2*W-1]}}, w_prod};
  assign w_neg   = ((r_opr == 4'b0100) && (r_cnt == 2'd1)) || ((r_opr == 4'b0111) && (r_cnt == 2'd2));
  assign w_term  = w_neg ? -w_ext : w_ext;
  assign w_to_re = (r_cnt == 2'd0) || ((r_cnt == 2'd1) && (r_opr != 4'b0110));
  assign w_sh_re = r_acc_re >>> FRAC;
  assign w_sh_im = r_acc_im >>> FRAC;
  assign w_m_re  = narrow(w_sh_re);
  assign w_m_im  = narrow(w_sh_im);

  always_comb begin
    w_e_re   = '0;
    w_e_im   = '0;
    w_e_raw  = 1'b0;
    w_e_word = '0;
    case (r_opr)
      4'b0000: begin w_e_re = {w_ra[W-1], w_ra}; w_e_im = {w_ia[W-1], w_ia}; end
      4'b0001: begin w_e_re = {w_rb[W-1], w_rb}; w_e_im = {w_ib[W-1], w_ib}; end
      4'b0010: begin
        w_e_re = {w_ra[W-1], w_ra} + {w_rb[W-1], w_rb};
        w_e_im = {w_ia[W-1], w_ia} + {w_ib[W-1], w_ib};
      end
      4'b0011: begin
        w_e_re = {w_ra[W-1], w_ra} - {w_rb[W-1], w_rb};
        w_e_im = {w_ia[W-1], w_ia} - {w_ib[W-1], w_ib};
      end
      4'b1000: begin w_e_raw = 1'b1; w_e_word = (r_a == r_b) ? {{(2*W-1){1'b0}}, 1'b1} : '0; end
      4'b1011: begin w_e_re = {w_ra[W-1], w_ra}; w_e_im = '0 - {w_ia[W-1], w_ia}; end
      4'b1100: begin w_e_re = '0 - {w_ra[W-1], w_ra}; w_e_im = '0 - {w_ia[W-1], w_ia}; end
      default: w_e_raw = 1'b1;
    endcase
  end

  assign w_n_re = narrow(sx1(w_e_re));
  assign w_n_im = narrow(sx1(w_e_im));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_opr    <= '0;
      r_cnt    <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_out    <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= inA;
        r_b      <= inB;
        r_opr    <= opr;
        r_cnt    <= '0;
        r_acc_re <= '0;
        r_acc_im <= '0;
      end
      if (r_state == S_MUL) begin
        r_cnt <= r_cnt + 2'd1;
        if (w_to_re) r_acc_re <= r_acc_re + w_term;
        else         r_acc_im <= r_acc_im + w_term;
      end
      if (r_state == S_EXEC) begin
        r_done <= 1'b1;
        if (w_e_raw) begin
          r_out <= w_e_word;
          r_ovf <= 1'b0;
        end else begin
          r_out <= {w_n_re[W-1:0], w_n_im[W-1:0]};
          r_ovf <= w_n_re[W] | w_n_im[W];
        end
      end
      if (r_state == S_NORM) begin
        r_done <= 1'b1;
        r_out  <= {w_m_re[W-1:0], w_m_im[W-1:0]};
        r_ovf  <= w_m_re[W] | w_m_im[W];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_calu_seq.sv
`default_nettype none
// tb_calu_seq : randomized self-checking bench; two instances (FRAC=0, FRAC=16) checked
// against a plain-arithmetic complex model.
module tb_calu_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] inA = '0, inB = '0;
  logic [3:0]  opr = '0;
  logic        start = 1'b0;
  logic [63:0] out0, out1;
  logic        done0, done1, busy0, busy1, ovf0, ovf1;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  calu_seq #(.W(32), .FRAC(0)) dut0 (
    .clock(clock), .reset(reset), .inA(inA), .inB(inB), .opr(opr), .start(start),
    .outAB(out0), .done(done0), .busy(busy0), .ovf(ovf0));
  calu_seq #(.W(32), .FRAC(16)) dut1 (
    .clock(clock), .reset(reset), .inA(inA), .inB(inB), .opr(opr), .start(start),
    .outAB(out1), .done(done1), .busy(busy1), .ovf(ovf1));

  // {overflow, 32-bit result} from an exact value
  function automatic logic [32:0] nar(input logic signed [127:0] v);
    logic signed [127:0] hi, lo;
    logic [31:0]         r;
    logic                o;
    hi = 128'sd2147483647;
    lo = -128'sd2147483648;
    o  = (v > hi) || (v < lo);
    r  = v[31:0];
`ifdef CALU_SAT_EN
    if (v > hi) r = 32'h7FFFFFFF;
    if (v < lo) r = 32'h80000000;
`endif
    return {o, r};
  endfunction

  function automatic void model(input logic [63:0] A, input logic [63:0] B, input logic [3:0] op,
                                input int frac, output logic [63:0] res, output logic ov,
                                output int lat);
    logic signed [127:0] a, b, c, d, re, im;
    logic [32:0]         nr, ni;
    a = {{96{A[63]}}, A[63:32]};
    b = {{96{A[31]}}, A[31:0]};
    c = {{96{B[63]}}, B[63:32]};
    d = {{96{B[31]}}, B[31:0]};
    re = 0; im = 0; lat = 1;
    case (op)
      4'd0:  begin re = a;     im = b;     end
      4'd1:  begin re = c;     im = d;     end
      4'd2:  begin re = a + c; im = b + d; end
      4'd3:  begin re = a - c; im = b - d; end
      4'd4:  begin re = (a*c - b*d) >>> frac; im = (a*d + b*c) >>> frac; lat = 5; end
      4'd6:  begin re = (a*c) >>> frac;       im = (b*d) >>> frac;       lat = 3; end
      4'd7:  begin re = (a*c + b*d) >>> frac; im = (b*c - a*d) >>> frac; lat = 5; end
      4'd11: begin re = a;  im = -b; end
      4'd12: begin re = -a; im = -b; end
      default: ;
    endcase
    nr  = nar(re);
    ni  = nar(im);
    res = {nr[31:0], ni[31:0]};
    ov  = nr[32] | ni[32];
    if (op == 4'd8) begin
      res = (A == B) ? 64'd1 : 64'd0;
      ov  = 1'b0;
    end else if (!(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd11, 4'd12})) begin
      res = '0;
      ov  = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'($urandom_range(0, 31)) - 32'd16;
      default: return $urandom();
    endcase
  endfunction

  // Drive a one-cycle start; returns just after the acceptance edge with inputs scrambled.
  task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    @(negedge clock);
    inA = a; inB = b; opr = op; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    inA = {$urandom(), $urandom()};
    inB = {$urandom(), $urandom()};
    opr = 4'($urandom_range(0, 15));
  endtask

  // Waits (bounded) for done; n counts edges since acceptance, 99 on timeout.
  task automatic wait_done(input int n0, output int n, output logic busy_ok, output logic both);
    n = n0;
    busy_ok = 1'b1;
    while (!done0 && n < 20) begin
      if (!busy0 || !busy1) busy_ok = 1'b0;
      @(negedge clock);
      n++;
    end
    if (!done0) n = 99;
    else if (busy0 || busy1) busy_ok = 1'b0;
    both = done0 & done1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({out0, out1} !== '0 || {done0, done1, busy0, busy1, ovf0, ovf1} !== '0) begin
      errors++;
      $display("FAIL reset_state got out0=%h out1=%h flags=%b required all zero", out0, out1,
               {done0, done1, busy0, busy1, ovf0, ovf1});
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [63:0] da[7], db[7], e0, e1;
    logic [3:0]  dop[7];
    logic        eo0, eo1, bok, bd;
    int          lat, lat1, n;
    da[0] = {32'd3, 32'd4};        db[0] = {32'd1, 32'hFFFFFFFE};  dop[0] = 4'b0010;
    da[1] = {32'd3, 32'd4};        db[1] = {32'd1, 32'hFFFFFFFE};  dop[1] = 4'b0100;
    da[2] = {32'd3, 32'd4};        db[2] = {32'd1, 32'hFFFFFFFE};  dop[2] = 4'b0111;
    da[3] = {32'd3, 32'd4};        db[3] = {32'd1, 32'hFFFFFFFE};  dop[3] = 4'b0110;
    da[4] = {32'h7FFFFFFF, 32'd0}; db[4] = {32'd1, 32'd0};         dop[4] = 4'b0010;
    da[5] = {32'h00018000, 32'd0}; db[5] = {32'h00020000, 32'd0};  dop[5] = 4'b0100;
    da[6] = {32'h80000000, 32'd7}; db[6] = '0;                     dop[6] = 4'b1100;
    for (int i = 0; i < 7; i++) begin
      model(da[i], db[i], dop[i], 0, e0, eo0, lat);
      model(da[i], db[i], dop[i], 16, e1, eo1, lat1);
      launch(da[i], db[i], dop[i]);
      wait_done(0, n, bok, bd);
      checks++;
      if (n !== lat) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d required %0d", i, n, lat);
      end
      checks++;
      if (out0 !== e0 || ovf0 !== eo0) begin
        errors++;
        $display("FAIL dir%0d_frac0 got %h/%b required %h/%b", i, out0, ovf0, e0, eo0);
      end
      checks++;
      if (out1 !== e1 || ovf1 !== eo1) begin
        errors++;
        $display("FAIL dir%0d_frac16 got %h/%b required %h/%b", i, out1, ovf1, e1, eo1);
      end
      checks++;
      if (!bok || !bd) begin
        errors++;
        $display("FAIL dir%0d_handshake got busy_ok=%b both_done=%b required 1/1", i, bok, bd);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, e0, e1;
    logic [3:0]  op;
    logic        eo0, eo1, bok, bd;
    int          lat, lat1, n;
    for (int i = 0; i < 60; i++) begin
      a  = {rnd32(), rnd32()};
      b  = {rnd32(), rnd32()};
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8 && $urandom_range(0, 1) == 1) b = a;
      model(a, b, op, 0, e0, eo0, lat);
      model(a, b, op, 16, e1, eo1, lat1);
      launch(a, b, op);
      wait_done(0, n, bok, bd);
      checks++;
      if (n !== lat || !bok || !bd) begin
        errors++;
        $display("FAIL rnd%0d_timing op=%h got lat=%0d busy_ok=%b both=%b required lat=%0d", i, op,
                 n, bok, bd, lat);
      end
      checks++;
      if (out0 !== e0 || ovf0 !== eo0 || out1 !== e1 || ovf1 !== eo1) begin
        errors++;
        $display("FAIL rnd%0d_result op=%h A=%h B=%h got %h/%b %h/%b required %h/%b %h/%b", i, op,
                 a, b, out0, ovf0, out1, ovf1, e0, eo0, e1, eo1);
      end
      @(negedge clock);
      checks++;
      if (done0 !== 1'b0 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_done_pulse got %b%b required 00", i, done0, done1);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [63:0] a, b, e0, e1;
    logic        eo0, eo1, bok, bd;
    int          lat, lat1, n, extra;
    a = {32'd3, 32'd4};
    b = {32'd1, 32'hFFFFFFFE};
    model(a, b, 4'b0100, 0, e0, eo0, lat);
    model(a, b, 4'b0100, 16, e1, eo1, lat1);
    launch(a, b, 4'b0100);
    @(negedge clock);
    inA = {32'd9, 32'd9}; opr = 4'b0000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(2, n, bok, bd);
    checks++;
    if (n !== 5 || out0 !== e0 || out1 !== e1) begin
      errors++;
      $display("FAIL ignore_busy got lat=%0d out=%h required lat=5 out=%h", n, out0, e0);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clock);
      if (done0 || done1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_busy_extra_done got %0d required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, e0, e1;
    logic [3:0]  op;
    logic        eo0, eo1, bok, bd;
    int          lat, lat1, n;
    launch({32'd1, 32'd2}, {32'd3, 32'd4}, 4'b0110);
    wait_done(0, n, bok, bd);
    for (int i = 0; i < 6; i++) begin
      a  = {rnd32(), rnd32()};
      b  = {rnd32(), rnd32()};
      op = (i % 2 == 0) ? 4'b0111 : 4'b0011;
      model(a, b, op, 0, e0, eo0, lat);
      model(a, b, op, 16, e1, eo1, lat1);
      inA = a; inB = b; opr = op; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      inA = '0;
      wait_done(0, n, bok, bd);
      checks++;
      if (n !== lat || out0 !== e0 || ovf0 !== eo0 || out1 !== e1 || ovf1 !== eo1) begin
        errors++;
        $display("FAIL b2b%0d op=%h got lat=%0d %h/%b required lat=%0d %h/%b", i, op, n, out0,
                 ovf0, lat, e0, eo0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic bok, bd;
    int   n, extra;
    launch({32'd3, 32'd4}, {32'd1, 32'hFFFFFFFE}, 4'b0100);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (out0 !== '0 || out1 !== '0 || {done0, done1, busy0, busy1, ovf0, ovf1} !== '0) begin
      errors++;
      $display("FAIL reset_mid got out=%h flags=%b required zero", out0,
               {done0, done1, busy0, busy1, ovf0, ovf1});
    end
    extra = 0;
    repeat (6) begin
      @(negedge clock);
      if (done0 || done1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL reset_mid_done got %0d required 0", extra);
    end
    launch({32'd5, 32'd5}, {32'd5, 32'd5}, 4'b1000);
    wait_done(0, n, bok, bd);
    checks++;
    if (n !== 1 || out0 !== 64'd1 || out1 !== 64'd1 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_eq got lat=%0d out=%h required lat=1 out=1", n, out0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
